// File: rtl/instr_fetch_decode.sv
// Instruction fetch and field decode: requests words from instruction memory,
// holds each one for the downstream stage, and follows redirects and halts.
module instr_fetch_decode #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  input  logic        halt,
  input  logic        instr_ready,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [63:0] instr_pc,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [11:0] funct12,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic        halted
);

  typedef enum logic [1:0] {FETCH, WAIT, HOLD, HALTED} state_t;

  state_t      state, state_n;
  logic [63:0] pc, pc_n;
  logic [63:0] addr_q, addr_n;
  logic        discard, discard_n;
  logic        halt_pend, halt_pend_n;
  logic        capture;
  logic [31:0] instr_q;
  logic [63:0] instr_pc_q;
  logic [63:0] cur_addr;
  logic [63:0] redir_pc;

  // WAIT presents the latched request address so a redirect cannot move it.
  assign cur_addr  = (state == WAIT) ? addr_q : pc;
  assign redir_pc  = {redirect_pc[63:2], 2'b00};
  assign imem_req  = !rst && ((state == FETCH) || (state == WAIT));
  assign imem_addr = {cur_addr[63:2], 2'b00};

  assign instr_valid = (state == HOLD);
  assign halted      = (state == HALTED);
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign opcode      = instr_q[6:0];
  assign funct3      = instr_q[14:12];
  assign funct7      = instr_q[31:25];
  assign funct12     = instr_q[31:20];
  assign rd          = instr_q[11:7];
  assign rs1         = instr_q[19:15];
  assign rs2         = instr_q[24:20];

  always_comb begin
    state_n     = state;
    pc_n        = pc;
    addr_n      = addr_q;
    discard_n   = discard;
    halt_pend_n = halt_pend;
    capture     = 1'b0;
    case (state)
      FETCH: begin
        if (halt) begin
          state_n = HALTED;
        end else if (imem_ack) begin
          if (redirect) begin
            pc_n = redir_pc;
          end else begin
            capture = 1'b1;
            state_n = HOLD;
          end
        end else begin
          addr_n  = pc;
          state_n = WAIT;
          if (redirect) begin
            pc_n      = redir_pc;
            discard_n = 1'b1;
          end
        end
      end
      WAIT: begin
        if (imem_ack) begin
          discard_n = 1'b0;
          if (halt || halt_pend) begin
            state_n = HALTED;
          end else if (redirect) begin
            pc_n    = redir_pc;
            state_n = FETCH;
          end else if (discard) begin
            state_n = FETCH;
          end else begin
            capture = 1'b1;
            state_n = HOLD;
          end
        end else if (halt) begin
          halt_pend_n = 1'b1;
        end else if (redirect) begin
          pc_n      = redir_pc;
          discard_n = 1'b1;
        end
      end
      HOLD: begin
        if (halt) begin
          state_n = HALTED;
        end else if (redirect) begin
          pc_n    = redir_pc;
          state_n = FETCH;
        end else if (instr_ready) begin
          pc_n    = instr_pc_q + 64'd4;
          state_n = FETCH;
        end
      end
      default: state_n = HALTED;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= FETCH;
      pc         <= {RESET_PC[63:2], 2'b00};
      addr_q     <= 64'h0;
      discard    <= 1'b0;
      halt_pend  <= 1'b0;
      instr_q    <= 32'h0;
      instr_pc_q <= 64'h0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      addr_q    <= addr_n;
      discard   <= discard_n;
      halt_pend <= halt_pend_n;
      if (capture) begin
        instr_q    <= imem_rdata;
        instr_pc_q <= cur_addr;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Bench for instr_fetch_decode: directed scenarios plus a randomized run
// compared cycle by cycle against a transaction-level reference model.
module tb_instr_fetch_decode;

  localparam logic [63:0] RESET_PC = 64'h0;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        halt;
  logic        instr_ready;
  logic        instr_valid;
  logic [31:0] instr;
  logic [63:0] instr_pc;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [11:0] funct12;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        halted;

  int n_checks = 0;
  int n_fail   = 0;

  instr_fetch_decode #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .halt(halt), .instr_ready(instr_ready),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .opcode(opcode), .funct3(funct3), .funct7(funct7), .funct12(funct12),
    .rd(rd), .rs1(rs1), .rs2(rs2), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Inputs change and outputs are sampled just after the falling edge.
  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    imem_ack    = 1'b0;
    imem_rdata  = 32'h0;
    redirect    = 1'b0;
    redirect_pc = 64'h0;
    halt        = 1'b0;
    instr_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    #1;
    n_checks++;
    if ({imem_req, instr_valid, halted} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_ctrl: req/valid/halted=%b expected 000", {imem_req, instr_valid, halted});
    end
    repeat (2) next_cycle();
    n_checks++;
    if ({instr, instr_pc} !== {32'h0, 64'h0}) begin
      n_fail++;
      $display("FAIL reset_data: instr=%h instr_pc=%h expected 0/0", instr, instr_pc);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if ({imem_req, imem_addr} !== {1'b1, RESET_PC}) begin
      n_fail++;
      $display("FAIL reset_first_req: req=%b addr=%h expected 1/%h", imem_req, imem_addr, RESET_PC);
    end
  endtask

  task automatic test_first_fetch();
    imem_ack   = 1'b1;
    imem_rdata = 32'h00A30293;
    next_cycle();
    imem_ack = 1'b0;
    n_checks++;
    if ({instr_valid, instr, instr_pc, imem_req} !== {1'b1, 32'h00A30293, 64'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL first_fetch: valid=%b instr=%h pc=%h req=%b expected 1/00a30293/0/0",
               instr_valid, instr, instr_pc, imem_req);
    end
    n_checks++;
    if ({opcode, rd, rs1, funct3, funct12} !== {7'h13, 5'd5, 5'd6, 3'd0, 12'h00A}) begin
      n_fail++;
      $display("FAIL first_decode: opcode=%h rd=%0d rs1=%0d funct3=%0d funct12=%h expected 13/5/6/0/00a",
               opcode, rd, rs1, funct3, funct12);
    end
  endtask

  task automatic test_hold_stable();
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      n_checks++;
      if ({instr_valid, instr, instr_pc, imem_req, opcode, rd} !==
          {1'b1, 32'h00A30293, 64'h0, 1'b0, 7'h13, 5'd5}) begin
        n_fail++;
        $display("FAIL hold_stable[%0d]: valid=%b instr=%h pc=%h req=%b expected 1/00a30293/0/0",
                 i, instr_valid, instr, instr_pc, imem_req);
      end
    end
    instr_ready = 1'b1;
    next_cycle();
    instr_ready = 1'b0;
    n_checks++;
    if ({instr_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 64'h4}) begin
      n_fail++;
      $display("FAIL hold_accept: valid=%b req=%b addr=%h expected 0/1/4", instr_valid, imem_req, imem_addr);
    end
  endtask

  task automatic test_wait_redirect();
    logic [31:0] w1, w2;
    w1 = $urandom;
    w2 = $urandom;
    imem_ack   = 1'b1;
    imem_rdata = w1;
    next_cycle();
    imem_ack = 1'b0;
    n_checks++;
    if ({instr_valid, instr, instr_pc} !== {1'b1, w1, 64'h4}) begin
      n_fail++;
      $display("FAIL second_fetch: valid=%b instr=%h pc=%h expected 1/%h/4", instr_valid, instr, instr_pc, w1);
    end
    instr_ready = 1'b1;
    next_cycle();
    instr_ready = 1'b0;
    next_cycle();
    redirect    = 1'b1;
    redirect_pc = 64'h103;
    next_cycle();
    redirect = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if ({imem_req, imem_addr, instr_valid} !== {1'b1, 64'h8, 1'b0}) begin
        n_fail++;
        $display("FAIL wait_addr[%0d]: req=%b addr=%h valid=%b expected 1/8/0", i, imem_req, imem_addr, instr_valid);
      end
      next_cycle();
    end
    imem_ack   = 1'b1;
    imem_rdata = ~w2;
    next_cycle();
    n_checks++;
    if ({instr_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 64'h100}) begin
      n_fail++;
      $display("FAIL wait_drop: valid=%b req=%b addr=%h expected 0/1/100", instr_valid, imem_req, imem_addr);
    end
    imem_rdata = w2;
    next_cycle();
    imem_ack = 1'b0;
    n_checks++;
    if ({instr_valid, instr, instr_pc} !== {1'b1, w2, 64'h100}) begin
      n_fail++;
      $display("FAIL redirect_fetch: valid=%b instr=%h pc=%h expected 1/%h/100", instr_valid, instr, instr_pc, w2);
    end
  endtask

  task automatic test_halt_redirect();
    halt        = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 64'h200;
    next_cycle();
    halt     = 1'b0;
    redirect = 1'b0;
    n_checks++;
    if ({halted, instr_valid, imem_req} !== 3'b100) begin
      n_fail++;
      $display("FAIL halt_enter: halted/valid/req=%b expected 100", {halted, instr_valid, imem_req});
    end
    for (int i = 0; i < 5; i++) begin
      imem_ack    = 1'($urandom);
      instr_ready = 1'b1;
      redirect    = 1'($urandom);
      next_cycle();
      n_checks++;
      if ({halted, instr_valid, imem_req} !== 3'b100) begin
        n_fail++;
        $display("FAIL halt_stays[%0d]: halted/valid/req=%b expected 100", i, {halted, instr_valid, imem_req});
      end
    end
    idle_inputs();
  endtask

  task automatic test_wrap();
    rst = 1'b1;
    idle_inputs();
    next_cycle();
    rst = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 32'h00000013;
    next_cycle();
    imem_ack    = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 64'hFFFF_FFFF_FFFF_FFFE;
    next_cycle();
    redirect = 1'b0;
    n_checks++;
    if ({instr_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC}) begin
      n_fail++;
      $display("FAIL wrap_redirect: valid=%b req=%b addr=%h expected 0/1/fffffffffffffffc",
               instr_valid, imem_req, imem_addr);
    end
    imem_ack = 1'b1;
    next_cycle();
    imem_ack    = 1'b0;
    instr_ready = 1'b1;
    n_checks++;
    if ({instr_valid, instr_pc} !== {1'b1, 64'hFFFF_FFFF_FFFF_FFFC}) begin
      n_fail++;
      $display("FAIL wrap_hold: valid=%b pc=%h expected 1/fffffffffffffffc", instr_valid, instr_pc);
    end
    next_cycle();
    instr_ready = 1'b0;
    n_checks++;
    if ({imem_req, imem_addr} !== {1'b1, 64'h0}) begin
      n_fail++;
      $display("FAIL wrap_next: req=%b addr=%h expected 1/0", imem_req, imem_addr);
    end
  endtask

  task automatic test_reset_in_wait();
    logic [31:0] w;
    w = $urandom;
    next_cycle();
    n_checks++;
    if ({imem_req, imem_addr} !== {1'b1, 64'h0}) begin
      n_fail++;
      $display("FAIL rstwait_pre: req=%b addr=%h expected 1/0", imem_req, imem_addr);
    end
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({imem_req, instr_valid, halted, instr, instr_pc, imem_addr} !==
        {3'b000, 32'h0, 64'h0, RESET_PC}) begin
      n_fail++;
      $display("FAIL rstwait_async: req=%b valid=%b halted=%b instr=%h pc=%h addr=%h expected 0/0/0/0/0/%h",
               imem_req, instr_valid, halted, instr, instr_pc, imem_addr, RESET_PC);
    end
    next_cycle();
    rst = 1'b0;
    #1;
    n_checks++;
    if ({imem_req, imem_addr} !== {1'b1, RESET_PC}) begin
      n_fail++;
      $display("FAIL rstwait_refetch: req=%b addr=%h expected 1/%h", imem_req, imem_addr, RESET_PC);
    end
    imem_ack   = 1'b1;
    imem_rdata = w;
    next_cycle();
    imem_ack = 1'b0;
    n_checks++;
    if ({instr_valid, instr, instr_pc} !== {1'b1, w, RESET_PC}) begin
      n_fail++;
      $display("FAIL rstwait_data: valid=%b instr=%h pc=%h expected 1/%h/%h", instr_valid, instr, instr_pc, w, RESET_PC);
    end
  endtask

  // Reference model: tracks whether a word is held, whether a request is in
  // flight (and its address), whether its data must be dropped, and halting.
  logic        m_halted, m_held, m_fly, m_drop, m_hafter;
  logic [63:0] m_pc, m_addr, m_ipc;
  logic [31:0] m_word;

  task automatic model_reset();
    m_halted = 1'b0;
    m_held   = 1'b0;
    m_fly    = 1'b0;
    m_drop   = 1'b0;
    m_hafter = 1'b0;
    m_pc     = RESET_PC & ~64'h3;
    m_addr   = 64'h0;
    m_ipc    = 64'h0;
    m_word   = 32'h0;
  endtask

  task automatic test_random(input int cycles);
    logic        a, rv, h, rdy, exp_req;
    logic [31:0] rdat;
    logic [63:0] rp, cur, exp_addr;
    rst = 1'b1;
    idle_inputs();
    next_cycle();
    rst = 1'b0;
    #1;
    model_reset();
    for (int i = 0; i < cycles; i++) begin
      if ((m_halted && $urandom_range(1) == 0) || $urandom_range(299) == 0) begin
        rst = 1'b1;
        idle_inputs();
        #1;
        n_checks++;
        if ({imem_req, instr_valid, halted, instr, instr_pc} !== {3'b000, 32'h0, 64'h0}) begin
          n_fail++;
          $display("FAIL rand_reset[%0d]: req=%b valid=%b halted=%b instr=%h pc=%h expected all zero",
                   i, imem_req, instr_valid, halted, instr, instr_pc);
        end
        model_reset();
        next_cycle();
        rst = 1'b0;
        #1;
      end
      exp_req  = !m_halted && !m_held;
      exp_addr = m_fly ? m_addr : m_pc;
      n_checks++;
      if ({imem_req, instr_valid, halted} !== {exp_req, m_held, m_halted}) begin
        n_fail++;
        $display("FAIL rand_ctrl[%0d]: req/valid/halted=%b expected %b",
                 i, {imem_req, instr_valid, halted}, {exp_req, m_held, m_halted});
      end
      if (exp_req) begin
        n_checks++;
        if (imem_addr !== exp_addr) begin
          n_fail++;
          $display("FAIL rand_addr[%0d]: addr=%h expected %h", i, imem_addr, exp_addr);
        end
      end
      if (m_held) begin
        n_checks++;
        if ({instr, instr_pc} !== {m_word, m_ipc}) begin
          n_fail++;
          $display("FAIL rand_instr[%0d]: instr=%h pc=%h expected %h/%h", i, instr, instr_pc, m_word, m_ipc);
        end
        n_checks++;
        if ({opcode, funct3, funct7, funct12, rd, rs1, rs2} !==
            {m_word[6:0], m_word[14:12], m_word[31:25], m_word[31:20],
             m_word[11:7], m_word[19:15], m_word[24:20]}) begin
          n_fail++;
          $display("FAIL rand_decode[%0d]: op=%h f3=%h f7=%h f12=%h rd=%h rs1=%h rs2=%h for word %h",
                   i, opcode, funct3, funct7, funct12, rd, rs1, rs2, m_word);
        end
      end
      a    = ($urandom_range(1) == 0);
      rdat = $urandom;
      rv   = ($urandom_range(7) == 0);
      rp   = {$urandom, $urandom};
      h    = ($urandom_range(39) == 0);
      rdy  = ($urandom_range(1) == 0);
      imem_ack = a; imem_rdata = rdat; redirect = rv; redirect_pc = rp;
      halt = h; instr_ready = rdy;
      if (!m_halted) begin
        if (m_held) begin
          if (h) begin
            m_halted = 1'b1; m_held = 1'b0;
          end else if (rv) begin
            m_pc = rp & ~64'h3; m_held = 1'b0;
          end else if (rdy) begin
            m_pc = m_ipc + 64'd4; m_held = 1'b0;
          end
        end else begin
          cur = m_fly ? m_addr : m_pc;
          if (a) begin
            m_fly = 1'b0;
            if (h || m_hafter) m_halted = 1'b1;
            else if (rv) begin
              m_pc = rp & ~64'h3; m_drop = 1'b0;
            end else if (m_drop) m_drop = 1'b0;
            else begin
              m_held = 1'b1; m_word = rdat; m_ipc = cur;
            end
          end else if (h) begin
            if (m_fly) m_hafter = 1'b1;
            else m_halted = 1'b1;
          end else begin
            if (!m_fly) begin
              m_fly = 1'b1; m_addr = m_pc;
            end
            if (rv) begin
              m_pc = rp & ~64'h3; m_drop = 1'b1;
            end
          end
        end
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_first_fetch();
    test_hold_stable();
    test_wait_redirect();
    test_halt_redirect();
    test_wrap();
    test_reset_in_wait();
    test_random(3000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
